// File: rtl/wb_downsizer_pkg.sv
// wb_downsizer_pkg: shared state encoding and geometry helpers for the Wishbone downsizer.
package wb_downsizer_pkg;
  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_e;
  function automatic int wb_ratio(input int m, input int s);
    return m / s;
  endfunction
  function automatic int wb_spg(input int s, input int g);
    return s / g;
  endfunction
  function automatic int wb_lo(input int s, input int g);
    return $clog2(s / g);
  endfunction
  function automatic int wb_bb(input int m, input int s);
    return $clog2(m / s);
  endfunction
  function automatic bit wb_legal(input int a, input int m, input int s, input int g);
    return (m == 16 || m == 32 || m == 64) && (s == 8 || s == 16 || s == 32) && s < m &&
           g > 0 && g <= s && s % g == 0 && a >= wb_lo(s, g) + wb_bb(m, s);
  endfunction
endpackage

// File: rtl/wb_next_lane.sv
// wb_next_lane: finds the lowest lane group above the current beat (or from the bottom) with a non-zero select.
module wb_next_lane #(
  parameter int RATIO = 4,
  parameter int SPG = 1,
  parameter int BB = 2
) (
  input  logic [RATIO*SPG-1:0] i_sel,
  input  logic [BB-1:0]        i_beat,
  input  logic                 i_first,
  output logic [BB-1:0]        o_next,
  output logic                 o_valid
);
  always_comb begin
    o_next = '0;
    o_valid = 1'b0;
    for (int i = RATIO - 1; i >= 0; i--)
      if (|i_sel[i*SPG +: SPG] && (i_first || i > int'(i_beat))) begin
        o_next = BB'(i);
        o_valid = 1'b1;
      end
  end
endmodule

// File: rtl/wb_downsizer.sv
// wb_downsizer: splits wide Wishbone classic accesses into narrow slave beats and reassembles read data.
module wb_downsizer
  import wb_downsizer_pkg::*;
#(
  parameter int ADR_BITS = 16,
  parameter int MASTER_PORT_SIZE = 32,
  parameter int SLAVE_PORT_SIZE = 8,
  parameter int GRANULARITY = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    m_cyc,
  input  logic                                    m_stb,
  input  logic                                    m_we,
  input  logic [ADR_BITS-1:0]                     m_adr,
  input  logic [MASTER_PORT_SIZE/GRANULARITY-1:0] m_sel,
  input  logic [MASTER_PORT_SIZE-1:0]             m_dat_i,
  output logic [MASTER_PORT_SIZE-1:0]             m_dat_o,
  output logic                                    m_ack,
  output logic                                    m_err,
  output logic                                    m_rty,
  output logic                                    s_cyc,
  output logic                                    s_stb,
  output logic                                    s_we,
  output logic [ADR_BITS-1:0]                     s_adr,
  output logic [SLAVE_PORT_SIZE/GRANULARITY-1:0]  s_sel,
  output logic [SLAVE_PORT_SIZE-1:0]              s_dat_o,
  input  logic [SLAVE_PORT_SIZE-1:0]              s_dat_i,
  input  logic                                    s_ack,
  input  logic                                    s_err,
  input  logic                                    s_rty
);
  localparam int RATIO = wb_ratio(MASTER_PORT_SIZE, SLAVE_PORT_SIZE);
  localparam int SPG = wb_spg(SLAVE_PORT_SIZE, GRANULARITY);
  localparam int LO = wb_lo(SLAVE_PORT_SIZE, GRANULARITY);
  localparam int BB = wb_bb(MASTER_PORT_SIZE, SLAVE_PORT_SIZE);
  localparam int MSEL = MASTER_PORT_SIZE / GRANULARITY;
  localparam int SW = SLAVE_PORT_SIZE;
  if (!wb_legal(ADR_BITS, MASTER_PORT_SIZE, SLAVE_PORT_SIZE, GRANULARITY)) begin : g_illegal
    $error("wb_downsizer: illegal port size / granularity combination");
  end
  state_e                      r_state;
  logic [ADR_BITS-1:0]         r_adr;
  logic                        r_we;
  logic [MSEL-1:0]             r_sel;
  logic [MASTER_PORT_SIZE-1:0] r_dat;
  logic [MASTER_PORT_SIZE-1:0] r_buf;
  logic [BB-1:0]               r_beat;
  logic                        w_idle;
  logic                        w_valid;
  logic [BB-1:0]               w_next;
  logic [MSEL-1:0]             w_sel;
  logic [ADR_BITS-1:0]         w_adr;
  logic [MASTER_PORT_SIZE-1:0] w_dat;
  logic [MASTER_PORT_SIZE-1:0] w_buf;
  // In IDLE the first beat is launched straight from the master inputs, so the lane search sees them directly.
  assign w_idle = r_state == IDLE;
  assign w_sel = w_idle ? m_sel : r_sel;
  assign w_adr = w_idle ? m_adr : r_adr;
  assign w_dat = w_idle ? m_dat_i : r_dat;
  wb_next_lane #(.RATIO(RATIO), .SPG(SPG), .BB(BB)) u_next (
    .i_sel(w_sel),
    .i_beat(r_beat),
    .i_first(w_idle),
    .o_next(w_next),
    .o_valid(w_valid)
  );
  always_comb begin
    w_buf = r_buf;
    w_buf[r_beat*SW +: SW] = s_dat_i;
  end
  function automatic logic [ADR_BITS-1:0] beat_adr(input logic [ADR_BITS-1:0] a, input logic [BB-1:0] b);
    logic [ADR_BITS-1:0] r;
    r = a & ~((ADR_BITS'(1) << LO) - ADR_BITS'(1));
    r[LO +: BB] = b;
    return r;
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_adr <= '0;
      r_we <= 1'b0;
      r_sel <= '0;
      r_dat <= '0;
      r_buf <= '0;
      r_beat <= '0;
      m_dat_o <= '0;
      m_ack <= 1'b0;
      m_err <= 1'b0;
      m_rty <= 1'b0;
      s_cyc <= 1'b0;
      s_stb <= 1'b0;
      s_we <= 1'b0;
      s_adr <= '0;
      s_sel <= '0;
      s_dat_o <= '0;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      m_rty <= 1'b0;
      case (r_state)
        IDLE: if (m_cyc && m_stb) begin
          r_adr <= m_adr;
          r_we <= m_we;
          r_sel <= m_sel;
          r_dat <= m_dat_i;
          r_buf <= '0;
          m_dat_o <= '0;
          s_we <= m_we;
          if (w_valid) begin
            r_beat <= w_next;
            s_cyc <= 1'b1;
            s_stb <= 1'b1;
            s_adr <= beat_adr(w_adr, w_next);
            s_sel <= w_sel[w_next*SPG +: SPG];
            s_dat_o <= w_dat[w_next*SW +: SW];
            r_state <= BEAT;
          end else begin
            m_ack <= 1'b1;
            r_state <= RESP;
          end
        end
        BEAT: if (!m_cyc) begin
          s_cyc <= 1'b0;
          s_stb <= 1'b0;
          r_state <= IDLE;
        end else if (s_err || s_rty) begin
          s_cyc <= 1'b0;
          s_stb <= 1'b0;
          m_err <= s_err;
          m_rty <= !s_err;
          m_dat_o <= r_buf;
          r_state <= RESP;
        end else if (s_ack) begin
          r_buf <= w_buf;
          if (w_valid) begin
            r_beat <= w_next;
            s_adr <= beat_adr(w_adr, w_next);
            s_sel <= w_sel[w_next*SPG +: SPG];
            s_dat_o <= w_dat[w_next*SW +: SW];
          end else begin
            s_cyc <= 1'b0;
            s_stb <= 1'b0;
            m_ack <= 1'b1;
            m_dat_o <= w_buf;
            r_state <= RESP;
          end
        end
        RESP: begin
          m_dat_o <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_downsizer.sv
// tb_wb_downsizer: table-driven and hand-sequenced checks of wb_downsizer (32->8 and 32->16) with scoreboards.
module tb_wb_downsizer;
  typedef struct { bit we; logic [15:0] adr; logic [3:0] sel; logic [31:0] dat; logic [31:0] edat; } vec_t;
  typedef struct { logic [15:0] adr; bit we; logic [7:0] dat; } beat_t;
  typedef struct { logic [2:0] kind; logic [31:0] dat; } resp_t;
  localparam logic [2:0] K_ACK = 3'b100, K_ERR = 3'b010, K_RTY = 3'b001;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0, checks = 0, terms = 0, s16_beats = 0;
  logic use16 = 1'b0, m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [15:0] m_adr = '0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_dat_i = '0;
  logic [17:0] last16 = '0;
  beat_t exp_beat[$];
  resp_t exp_resp[$];

  logic [31:0] m8_dat_o, m16_dat_o;
  logic m8_ack, m8_err, m8_rty, m16_ack, m16_err, m16_rty;
  logic s8_cyc, s8_stb, s8_we, s8_ack, s8_err, s8_rty, s8_rdy, s8_hit;
  logic [15:0] s8_adr, s16_adr;
  logic [0:0] s8_sel;
  logic [7:0] s8_dat_o, s8_dat_i;
  logic s16_cyc, s16_stb, s16_we, s16_ack, s16_err, s16_rty;
  logic [1:0] s16_sel;
  logic [15:0] s16_dat_o, s16_dat_i;

  wb_downsizer #(.ADR_BITS(16), .MASTER_PORT_SIZE(32), .SLAVE_PORT_SIZE(8), .GRANULARITY(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc && !use16), .m_stb(m_stb && !use16), .m_we(m_we),
    .m_adr(m_adr), .m_sel(m_sel), .m_dat_i(m_dat_i), .m_dat_o(m8_dat_o), .m_ack(m8_ack),
    .m_err(m8_err), .m_rty(m8_rty), .s_cyc(s8_cyc), .s_stb(s8_stb), .s_we(s8_we), .s_adr(s8_adr),
    .s_sel(s8_sel), .s_dat_o(s8_dat_o), .s_dat_i(s8_dat_i), .s_ack(s8_ack), .s_err(s8_err), .s_rty(s8_rty));

  wb_downsizer #(.ADR_BITS(16), .MASTER_PORT_SIZE(32), .SLAVE_PORT_SIZE(16), .GRANULARITY(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc && use16), .m_stb(m_stb && use16), .m_we(m_we),
    .m_adr(m_adr), .m_sel(m_sel), .m_dat_i(m_dat_i), .m_dat_o(m16_dat_o), .m_ack(m16_ack),
    .m_err(m16_err), .m_rty(m16_rty), .s_cyc(s16_cyc), .s_stb(s16_stb), .s_we(s16_we), .s_adr(s16_adr),
    .s_sel(s16_sel), .s_dat_o(s16_dat_o), .s_dat_i(s16_dat_i), .s_ack(s16_ack), .s_err(s16_err), .s_rty(s16_rty));

  // Byte slave: zero-wait combinational ack, optional fault on one beat index, optional endless stall.
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  int fault_beat = -1, fault_kind = 0, stall_beat = -1, beat_idx = 0;
  always_comb begin
    s8_rdy = s8_cyc && s8_stb && beat_idx != stall_beat;
    s8_hit = s8_rdy && beat_idx == fault_beat;
    s8_err = s8_hit && fault_kind != 1;
    s8_rty = s8_hit && fault_kind != 0;
    s8_ack = s8_rdy && !s8_hit;
    s8_dat_i = s8_we ? 8'h00 : mem[s8_adr[9:0]];
  end
  always @(posedge clk) begin
    if (!(s8_cyc && s8_stb)) beat_idx <= 0;
    else if (s8_ack || s8_err || s8_rty) beat_idx <= beat_idx + 1;
    if (s8_ack && s8_we) mem[s8_adr[9:0]] <= s8_dat_o;
  end
  assign s16_ack = s16_cyc && s16_stb;
  assign s16_err = 1'b0;
  assign s16_rty = 1'b0;
  assign s16_dat_i = 16'hBEEF;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%h required=%h", nm, got, exp);
    end
  endfunction

  function automatic void fail(input string nm, input logic [63:0] got);
    checks++;
    errs++;
    $display("FAIL %s: got=%h required=nothing", nm, got);
  endfunction

  function automatic void push_beats(input logic [15:0] adr, input logic [3:0] sel, input bit we,
                                     input logic [31:0] dat, input int nmax);
    int n = 0;
    for (int b = 0; b < 4; b++)
      if (sel[b] && n < nmax) begin
        exp_beat.push_back('{(adr & 16'hFFFC) | 16'(b), we, we ? dat[b*8 +: 8] : 8'h00});
        n++;
      end
  endfunction

  task automatic cycle();
    beat_t b;
    resp_t r;
    @(negedge clk);
    if (s8_cyc && s8_stb && (s8_ack || s8_err || s8_rty)) begin
      if (exp_beat.size() == 0) fail("s8_beat_extra", 64'(s8_adr));
      else begin
        b = exp_beat.pop_front();
        chk("s8_beat", 64'({s8_adr, s8_we, s8_sel, s8_we ? s8_dat_o : 8'h00}), 64'({b.adr, b.we, 1'b1, b.dat}));
      end
    end
    if (s16_cyc && s16_stb && s16_ack) begin
      s16_beats++;
      last16 = {s16_adr, s16_sel};
    end
    if (m8_ack || m8_err || m8_rty || m16_ack || m16_err || m16_rty) begin
      terms++;
      if (exp_resp.size() == 0) fail("m_resp_extra", 64'({m8_ack, m8_err, m8_rty, m16_ack, m16_err, m16_rty}));
      else begin
        r = exp_resp.pop_front();
        chk("m_resp", use16 ? 64'({m16_ack, m16_err, m16_rty, m16_dat_o}) : 64'({m8_ack, m8_err, m8_rty, m8_dat_o}),
            64'({r.kind, r.dat}));
      end
    end
  endtask

  task automatic do_req(input bit u16, input bit we, input logic [15:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [2:0] kind, input logic [31:0] edat, input int lat);
    int n = 0;
    int t0 = terms;
    use16 = u16; m_we = we; m_adr = adr; m_sel = sel; m_dat_i = dat;
    m_cyc = 1'b1; m_stb = 1'b1;
    exp_resp.push_back('{kind, edat});
    while (terms == t0 && n < 60) begin
      cycle();
      n++;
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    if (terms == t0) begin
      fail("timeout", 64'(n));
      exp_resp.delete();
    end else chk("latency", 64'(n), 64'(lat));
    cycle();
    cycle();
    chk("beats_left", 64'(exp_beat.size()), 64'd0);
    exp_beat.delete();
  endtask

  initial begin
    vec_t tbl[10];
    int t0;
    tbl[0] = '{1'b1, 16'h0100, 4'hF, 32'hA1B2C3D4, 32'h00000000};
    tbl[1] = '{1'b0, 16'h0100, 4'hF, 32'h00000000, 32'hA1B2C3D4};
    tbl[2] = '{1'b1, 16'h0200, 4'h6, 32'h00221100, 32'h00000000};
    tbl[3] = '{1'b0, 16'h0200, 4'h6, 32'h00000000, 32'h00221100};
    tbl[4] = '{1'b1, 16'h0104, 4'h5, 32'h11223344, 32'h00000000};
    tbl[5] = '{1'b0, 16'h0104, 4'hF, 32'h00000000, 32'h00220044};
    tbl[6] = '{1'b0, 16'h0103, 4'h8, 32'h00000000, 32'hA1000000};
    tbl[7] = '{1'b1, 16'h0108, 4'h0, 32'hDEADBEEF, 32'h00000000};
    tbl[8] = '{1'b0, 16'h0100, 4'h1, 32'h00000000, 32'h000000D4};
    tbl[9] = '{1'b0, 16'h0108, 4'hF, 32'h00000000, 32'h00000000};
    repeat (3) @(negedge clk);
    chk("rst_out8", 64'({m8_dat_o, m8_ack, m8_err, m8_rty, s8_cyc, s8_stb, s8_we, s8_adr, s8_sel, s8_dat_o}), 64'd0);
    chk("rst_out16", 64'({m16_dat_o, m16_ack, m16_err, m16_rty, s16_cyc, s16_stb, s16_we, s16_sel}), 64'd0);
    rst_n = 1'b1;
    cycle();
    for (int i = 0; i < 10; i++) begin
      push_beats(tbl[i].adr, tbl[i].sel, tbl[i].we, tbl[i].dat, 4);
      do_req(1'b0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, K_ACK, tbl[i].edat, $countones(tbl[i].sel) + 1);
    end
    // 32->16: empty select never reaches the slave; upper half lands on the odd half-word address
    do_req(1'b1, 1'b0, 16'h0010, 4'h0, 32'h0, K_ACK, 32'h0, 1);
    chk("s16_none", 64'(s16_beats), 64'd0);
    do_req(1'b1, 1'b0, 16'h0010, 4'hC, 32'h0, K_ACK, 32'hBEEF0000, 2);
    chk("s16_count", 64'(s16_beats), 64'd1);
    chk("s16_beat", 64'(last16), 64'({16'h0012, 2'b11}));
    // slave faults: err on 2nd beat, rty on 1st, err+rty together
    fault_beat = 1; fault_kind = 0;
    push_beats(16'h0100, 4'hF, 1'b0, 32'h0, 2);
    do_req(1'b0, 1'b0, 16'h0100, 4'hF, 32'h0, K_ERR, 32'h000000D4, 3);
    fault_beat = 0; fault_kind = 1;
    push_beats(16'h0200, 4'h6, 1'b0, 32'h0, 1);
    do_req(1'b0, 1'b0, 16'h0200, 4'h6, 32'h0, K_RTY, 32'h0, 2);
    fault_kind = 2;
    push_beats(16'h0300, 4'h3, 1'b1, 32'h00007788, 1);
    do_req(1'b0, 1'b1, 16'h0300, 4'h3, 32'h00007788, K_ERR, 32'h0, 2);
    fault_beat = -1;
    push_beats(16'h0300, 4'h3, 1'b0, 32'h0, 4);
    do_req(1'b0, 1'b0, 16'h0300, 4'h3, 32'h0, K_ACK, 32'h0, 3);
    // master abort while beat 2 stalls
    stall_beat = 1;
    t0 = terms;
    push_beats(16'h0400, 4'hF, 1'b1, 32'h55667788, 1);
    use16 = 1'b0; m_we = 1'b1; m_adr = 16'h0400; m_sel = 4'hF; m_dat_i = 32'h55667788;
    m_cyc = 1'b1; m_stb = 1'b1;
    cycle();
    cycle();
    chk("abort_pre", 64'({s8_cyc, s8_stb, s8_adr}), 64'({2'b11, 16'h0401}));
    m_cyc = 1'b0; m_stb = 1'b0;
    cycle();
    chk("abort_drop", 64'({s8_cyc, s8_stb}), 64'd0);
    repeat (4) cycle();
    chk("abort_noterm", 64'(terms - t0), 64'd0);
    chk("abort_beats", 64'(exp_beat.size()), 64'd0);
    stall_beat = -1;
    push_beats(16'h0100, 4'hF, 1'b0, 32'h0, 4);
    do_req(1'b0, 1'b0, 16'h0100, 4'hF, 32'h0, K_ACK, 32'hA1B2C3D4, 5);
    // asynchronous reset in the middle of a stalled beat
    stall_beat = 1;
    push_beats(16'h0500, 4'hF, 1'b1, 32'h99AABBCC, 1);
    m_we = 1'b1; m_adr = 16'h0500; m_sel = 4'hF; m_dat_i = 32'h99AABBCC;
    m_cyc = 1'b1; m_stb = 1'b1;
    cycle();
    cycle();
    chk("rst_pre", 64'({s8_cyc, s8_adr, s8_dat_o}), 64'({1'b1, 16'h0501, 8'hBB}));
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 64'({m8_dat_o, m8_ack, m8_err, m8_rty, s8_cyc, s8_stb, s8_we, s8_adr, s8_sel, s8_dat_o}), 64'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    #1 rst_n = 1'b1;
    stall_beat = -1;
    exp_beat.delete();
    cycle();
    cycle();
    push_beats(16'h0500, 4'h1, 1'b0, 32'h0, 4);
    do_req(1'b0, 1'b0, 16'h0500, 4'h1, 32'h0, K_ACK, 32'h000000CC, 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
